// File: rtl/wb_slot_scheduler_pkg.sv
// Shared types and default latencies for the writeback-slot scheduler.
package wb_slot_scheduler_pkg;

    localparam int ROB_ID_W        = 6;
    localparam int ALU_MUL_LATENCY = 5;
    localparam int WB_ALU_LATENCY  = 1;
    localparam int WB_MUL_LATENCY  = ALU_MUL_LATENCY;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MUL = 1'b1
    } wb_unit_t;

    typedef struct packed {
        logic                valid;
        wb_unit_t            unit;
        logic [ROB_ID_W-1:0] instr_id;
    } wb_slot_t;

endpackage

// File: rtl/wb_slot_scheduler_if.sv
// Decode issue handshake, WB-stage report and published slot for the scheduler.
interface wb_slot_scheduler_if;
    import wb_slot_scheduler_pkg::*;

    logic                issue_valid;
    wb_unit_t            issue_unit;
    logic [ROB_ID_W-1:0] issue_instr_id;
    logic                issue_needs_wb;
    logic                issue_grant;
    logic                stall_decode;

    logic                wb_valid;
    wb_unit_t            wb_unit;
    logic [ROB_ID_W-1:0] wb_instr_id;

    logic                slot_valid;
    wb_unit_t            slot_unit;
    logic [ROB_ID_W-1:0] slot_instr_id;

    modport master (
        output issue_valid, issue_unit, issue_instr_id, issue_needs_wb,
        output wb_valid, wb_unit, wb_instr_id,
        input  issue_grant, stall_decode,
        input  slot_valid, slot_unit, slot_instr_id
    );

    modport slave (
        input  issue_valid, issue_unit, issue_instr_id, issue_needs_wb,
        input  wb_valid, wb_unit, wb_instr_id,
        output issue_grant, stall_decode,
        output slot_valid, slot_unit, slot_instr_id
    );

endinterface

// File: rtl/wb_slot_scheduler.sv
// Reserves shared writeback cycles for ALU/MUL issues on a shifting timeline,
// stalls decode on a slot collision and cross-checks the WB stage.
module wb_slot_scheduler
    import wb_slot_scheduler_pkg::*;
#(
    parameter int ALU_LATENCY = WB_ALU_LATENCY,
    parameter int MUL_LATENCY = WB_MUL_LATENCY
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               flush,
    wb_slot_scheduler_if.slave                 bus,
    output logic [$clog2(MUL_LATENCY+1)-1:0]   mul_inflight,
    output logic                               sched_error
);

    localparam int D     = MUL_LATENCY;
    localparam int CNT_W = $clog2(MUL_LATENCY+1);

    wb_slot_t timeline     [D];
    wb_slot_t timeline_nxt [D];
    wb_slot_t issue_entry;

    logic kill;
    logic needs_slot;
    logic target_free;
    logic grant;
    logic mul_issue;
    logic mul_retire;
    logic mismatch;

    assign kill        = reset | flush;
    assign needs_slot  = (bus.issue_unit == WB_MUL) | bus.issue_needs_wb;
    // A MUL targets the slot that is empty after every shift, so it never collides.
    assign target_free = (bus.issue_unit == WB_MUL) | !timeline[ALU_LATENCY].valid;
    assign grant       = bus.issue_valid & !kill & (!needs_slot | target_free);

    assign issue_entry = '{valid: 1'b1, unit: bus.issue_unit, instr_id: bus.issue_instr_id};

    always_comb begin
        for (int k = 0; k < D-1; k++) begin
            timeline_nxt[k] = timeline[k+1];
        end
        timeline_nxt[D-1] = '0;
        if (grant && needs_slot) begin
            if (bus.issue_unit == WB_MUL) begin
                timeline_nxt[MUL_LATENCY-1] = issue_entry;
            end else begin
                timeline_nxt[ALU_LATENCY-1] = issue_entry;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int k = 0; k < D; k++) begin
            if (kill) begin
                timeline[k] <= '0;
            end else begin
                timeline[k] <= timeline_nxt[k];
            end
        end
    end

    assign mul_issue  = grant & (bus.issue_unit == WB_MUL);
    assign mul_retire = timeline[0].valid & (timeline[0].unit == WB_MUL);

    always_ff @(posedge clock) begin
        if (kill) begin
            mul_inflight <= '0;
        end else if (mul_issue && !mul_retire) begin
            mul_inflight <= mul_inflight + CNT_W'(1);
        end else if (!mul_issue && mul_retire) begin
            mul_inflight <= mul_inflight - CNT_W'(1);
        end
    end

    // Flush squashes the writeback in flight, so its report is not trusted.
    assign mismatch = !flush &
                      ((timeline[0].valid != bus.wb_valid) |
                       (timeline[0].valid & bus.wb_valid &
                        ((timeline[0].unit != bus.wb_unit) |
                         (timeline[0].instr_id != bus.wb_instr_id))));

    always_ff @(posedge clock) begin
        if (reset) begin
            sched_error <= 1'b0;
        end else if (mismatch) begin
            sched_error <= 1'b1;
        end
    end

    assign bus.issue_grant   = grant;
    assign bus.stall_decode  = bus.issue_valid & !grant;
    assign bus.slot_valid    = timeline[0].valid;
    assign bus.slot_unit     = timeline[0].unit;
    assign bus.slot_instr_id = timeline[0].instr_id;

endmodule

// File: tb/tb_wb_slot_scheduler.sv
// Scoreboard bench: bookings keyed by absolute writeback cycle, checked by a negedge monitor.
module tb_wb_slot_scheduler;
    import wb_slot_scheduler_pkg::*;

    localparam int ALU_L = WB_ALU_LATENCY;
    localparam int MUL_L = WB_MUL_LATENCY;

    typedef struct {
        int                  due;
        wb_unit_t            unit;
        logic [ROB_ID_W-1:0] id;
    } booking_t;

    logic clock = 1'b0;
    logic reset;
    logic flush;
    logic [$clog2(MUL_L+1)-1:0] mul_inflight;
    logic sched_error;

    wb_slot_scheduler_if bus();

    wb_slot_scheduler #(.ALU_LATENCY(ALU_L), .MUL_LATENCY(MUL_L)) dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .bus          (bus),
        .mul_inflight (mul_inflight),
        .sched_error  (sched_error)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    booking_t sb[$];
    bit chk_en  = 1'b0;
    bit exp_err = 1'b0;

    bit                  cur_valid = 1'b0;
    wb_unit_t            cur_unit  = WB_ALU;
    logic [ROB_ID_W-1:0] cur_id    = '0;
    logic [ROB_ID_W-1:0] id_ctr    = '0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: the booking due this cycle must be on the slot outputs.
    always @(negedge clock) begin
        if (chk_en) begin
            int n_mul;
            n_mul = 0;
            foreach (sb[i]) if (sb[i].unit == WB_MUL) n_mul++;
            cur_valid = 1'b0;
            cur_unit  = WB_ALU;
            cur_id    = '0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                cur_valid = 1'b1;
                cur_unit  = sb[0].unit;
                cur_id    = sb[0].id;
                void'(sb.pop_front());
            end
            chk("slot_valid", bus.slot_valid, cur_valid);
            if (cur_valid) begin
                chk("slot_unit", bus.slot_unit, cur_unit);
                chk("slot_instr_id", bus.slot_instr_id, cur_id);
            end
            chk("mul_inflight", mul_inflight, n_mul);
            chk("sched_error", sched_error, exp_err);
        end
    end

    task automatic step(input bit v, input wb_unit_t unit, input logic [ROB_ID_W-1:0] id,
                        input bit nwb, input bit fl, input bit rst, input bit inj);
        bit       exp_grant;
        bit       mism;
        booking_t b;
        int       pos;
        @(negedge clock);
        #1;
        reset                = rst;
        flush                = fl;
        bus.issue_valid      = v;
        bus.issue_unit       = unit;
        bus.issue_instr_id   = id;
        bus.issue_needs_wb   = nwb;
        bus.wb_valid         = cur_valid | inj;
        bus.wb_unit          = cur_unit;
        bus.wb_instr_id      = (inj && cur_valid) ? (cur_id ^ ROB_ID_W'(4)) : cur_id;
        mism = (cur_valid != bus.wb_valid) ||
               (cur_valid && bus.wb_valid &&
                (cur_unit != bus.wb_unit || cur_id != bus.wb_instr_id));
        exp_grant = v && !fl && !rst;
        if (exp_grant && unit == WB_ALU && nwb)
            foreach (sb[i]) if (sb[i].due == cyc + ALU_L) exp_grant = 1'b0;
        #1;
        if (chk_en) begin
            chk("issue_grant", bus.issue_grant, exp_grant);
            chk("stall_decode", bus.stall_decode, v && !exp_grant);
        end
        if (rst) exp_err = 1'b0;
        else if (!fl && mism) exp_err = 1'b1;
        if (fl || rst) sb.delete();
        if (exp_grant && (unit == WB_MUL || nwb)) begin
            b.due  = cyc + ((unit == WB_MUL) ? MUL_L : ALU_L);
            b.unit = unit;
            b.id   = id;
            pos    = sb.size();
            for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].due > b.due) pos = i;
            sb.insert(pos, b);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, WB_ALU, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_bad);
        $fatal(1);
    end

    initial begin
        reset              = 1'b1;
        flush              = 1'b0;
        bus.issue_valid    = 1'b0;
        bus.issue_unit     = WB_ALU;
        bus.issue_instr_id = '0;
        bus.issue_needs_wb = 1'b0;
        bus.wb_valid       = 1'b0;
        bus.wb_unit        = WB_ALU;
        bus.wb_instr_id    = '0;

        @(posedge clock);
        #1;
        chk_en = 1'b1;
        chk("reset_slot_valid", bus.slot_valid, 0);
        chk("reset_slot_unit", bus.slot_unit, 0);
        chk("reset_slot_instr_id", bus.slot_instr_id, 0);
        chk("reset_mul_inflight", mul_inflight, 0);
        chk("reset_sched_error", sched_error, 0);
        reset              = 1'b0;
        bus.issue_valid    = 1'b1;
        bus.issue_needs_wb = 1'b1;
        #1;
        chk("reset_grant_follows_valid", bus.issue_grant, 1);
        chk("reset_no_stall", bus.stall_decode, 0);
        bus.issue_valid = 1'b0;
        step(1'b0, WB_ALU, '0, 1'b0, 1'b0, 1'b1, 1'b0);

        // ALU collides with an older MUL, stalls one cycle, then lands right after it
        step(1'b1, WB_MUL, 6'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        step(1'b1, WB_ALU, 6'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("plan_conflict_stall", bus.stall_decode, 1);
        step(1'b1, WB_ALU, 6'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("plan_conflict_grant", bus.issue_grant, 1);
        idle(4);

        // ALU without a result needs no slot
        step(1'b1, WB_MUL, 6'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        step(1'b1, WB_ALU, 6'd11, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("plan_nowb_grant", bus.issue_grant, 1);
        idle(6);

        for (int i = 0; i < 5; i++) begin
            step(1'b1, WB_MUL, ROB_ID_W'(20 + i), 1'b1, 1'b0, 1'b0, 1'b0);
            chk("plan_b2b_mul_grant", bus.issue_grant, 1);
        end
        chk("plan_b2b_peak", mul_inflight, 4);
        idle(1);
        chk("plan_b2b_full", mul_inflight, 5);
        idle(6);

        step(1'b1, WB_MUL, 6'd30, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, WB_MUL, 6'd31, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, WB_ALU, 6'd32, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("plan_flush_nogrant", bus.issue_grant, 0);
        idle(7);

        // WB reports id 7 while the slot expects id 3
        step(1'b1, WB_MUL, 6'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        step(1'b0, WB_ALU, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("plan_error_set", sched_error, 1);
        idle(3);
        chk("plan_error_sticky", sched_error, 1);

        step(1'b1, WB_MUL, 6'd40, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, WB_MUL, 6'd41, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, WB_MUL, 6'd42, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, WB_ALU, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        chk("plan_reset_inflight", mul_inflight, 0);
        chk("plan_reset_error", sched_error, 0);
        idle(6);

        for (int n = 0; n < 400; n++) begin
            bit       rst;
            bit       fl;
            bit       v;
            bit       nwb;
            bit       inj;
            wb_unit_t unit;
            rst  = ($urandom_range(0, 99) < 1);
            fl   = !rst && ($urandom_range(0, 99) < 4);
            v    = !rst && ($urandom_range(0, 99) < 75);
            unit = ($urandom_range(0, 99) < 35) ? WB_MUL : WB_ALU;
            nwb  = ($urandom_range(0, 99) < 85);
            inj  = ($urandom_range(0, 99) < 2);
            step(v, unit, id_ctr, nwb, fl, rst, inj);
            id_ctr++;
        end
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
